// File: rtl/pixel_packer_pkg.sv
// Shared GPU constants: core-array geometry and pixel packer defaults.
package pixel_packer_pkg;

  // Core array geometry (the producer of the serial result bits).
  localparam int CORE_ROWS = 8;
  localparam int CORE_COLS = 8;

  // Pixel packer defaults and their derived widths.
  localparam int PIXEL_BITS_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FIFO_PTR_W_DEF = $clog2(FIFO_DEPTH_DEF);
  localparam int FIFO_LVL_W_DEF = FIFO_PTR_W_DEF + 1;

  // Width of a counter that must hold 0..pixel_bits-1 (at least 1 bit).
  function automatic int cnt_width(input int pixel_bits);
    return $clog2(pixel_bits + 1);
  endfunction

endpackage

// File: rtl/pixel_packer_sync_fifo.sv
// Small synchronous FIFO with occupancy level and a synchronous clear.
module sync_fifo
  import pixel_packer_pkg::*;
#(
  parameter int WIDTH = PIXEL_BITS_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is only accepted when a pop frees a slot this cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointer and level bookkeeping; clear wins over any push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
    end
  end

  // Storage; reset to zero so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!clear && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs the core array's serial result bits (MSB first) into pixels and
// buffers them for the VGA stage.
//
// Output handshake: pixel_data is offered while pixel_valid=1 and is held
// stable until the cycle where pixel_valid=1 and pixel_ready=1, which pops
// it; pixel_ready while pixel_valid=0 does nothing.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int PIXEL_BITS = PIXEL_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_valid,
  input  logic                          bit_in,
  input  logic                          flush,
  input  logic                          clear_overflow,
  output logic [PIXEL_BITS-1:0]         pixel_data,
  output logic                          pixel_valid,
  input  logic                          pixel_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow
);

  localparam int CNT_W = cnt_width(PIXEL_BITS);

  logic [CNT_W-1:0]      bit_cnt;
  logic [PIXEL_BITS-1:0] partial;
  logic [PIXEL_BITS-1:0] shifted;
  logic                  last_bit;
  logic                  push_req;
  logic                  pop_req;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  drop;

  assign pixel_valid = !fifo_empty;

  // Shift-in view of the partial pixel and the push/pop/drop decisions.
  always_comb begin
    shifted    = partial << 1;
    shifted[0] = bit_in;
    last_bit   = bit_valid && (bit_cnt == CNT_W'(PIXEL_BITS - 1));
    push_req   = last_bit && !flush;
    pop_req    = pixel_valid && pixel_ready && !flush;
    drop       = push_req && fifo_full && !pop_req;
  end

  // Serial-to-parallel shifter; a completed pixel leaves and the shifter restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      partial <= '0;
    end else if (flush) begin
      bit_cnt <= '0;
      partial <= '0;
    end else if (bit_valid) begin
      if (last_bit) begin
        bit_cnt <= '0;
        partial <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        partial <= shifted;
      end
    end
  end

  // Sticky overflow: a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 1'b0;
    else        overflow <= drop || (overflow && !clear_overflow);
  end

  sync_fifo #(
    .WIDTH (PIXEL_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push_req),
    .pop   (pop_req),
    .din   (shifted),
    .dout  (pixel_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fill_level)
  );

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with PIXEL_BITS=2, FIFO_DEPTH=4.
module tb_pixel_packer;

  logic       clk;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic       flush;
  logic       clear_overflow;
  logic [1:0] pixel_data;
  logic       pixel_valid;
  logic       pixel_ready;
  logic [2:0] fill_level;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] exp_q[$];

  pixel_packer #(
    .PIXEL_BITS (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bit_valid      (bit_valid),
    .bit_in         (bit_in),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .pixel_data     (pixel_data),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .fill_level     (fill_level),
    .overflow       (overflow)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Driver tasks; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_pixel(input logic [1:0] p);
    send_bit(p[1]);
    send_bit(p[0]);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 16 && pixel_valid; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_extra"}, 32'(pixel_data), 32'hdead);
      end else begin
        check({tag, "_data"}, 32'(pixel_data), 32'(exp_q.pop_front()));
      end
      pixel_ready = 1'b1;
      tick();
      pixel_ready = 1'b0;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_fill"}, 32'(fill_level), 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    bit_valid      = 1'b0;
    bit_in         = 1'b0;
    flush          = 1'b0;
    clear_overflow = 1'b0;
    pixel_ready    = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_fill",  32'(fill_level),  32'd0);
    check("rst_ovf",   32'(overflow),    32'd0);
    check("rst_data",  32'(pixel_data),  32'd0);
    reset = 1'b1;
    tick();

    // Back-to-back pixels with the consumer always ready.
    pixel_ready = 1'b1;
    send_bit(1'b1);
    check("s1_valid_a", 32'(pixel_valid), 32'd0);
    send_bit(1'b0);
    check("s1_valid_b", 32'(pixel_valid), 32'd1);
    check("s1_data_b",  32'(pixel_data),  32'h2);
    send_bit(1'b1);
    check("s1_valid_c", 32'(pixel_valid), 32'd0);
    send_bit(1'b1);
    check("s1_valid_d", 32'(pixel_valid), 32'd1);
    check("s1_data_d",  32'(pixel_data),  32'h3);
    tick();
    check("s1_valid_e", 32'(pixel_valid), 32'd0);
    pixel_ready = 1'b0;

    // Idle cycles between bits do not disturb the shifter.
    send_bit(1'b0);
    bit_in = 1'b1;
    repeat (3) tick();
    bit_in = 1'b0;
    check("s2_fill_idle", 32'(fill_level), 32'd0);
    send_bit(1'b1);
    check("s2_fill", 32'(fill_level), 32'd1);
    exp_q.push_back(2'b01);
    drain("s2");

    // Overflow: five pixels into a four-deep FIFO with no consumer.
    send_pixel(2'b00); exp_q.push_back(2'b00);
    send_pixel(2'b01); exp_q.push_back(2'b01);
    send_pixel(2'b10); exp_q.push_back(2'b10);
    send_pixel(2'b11); exp_q.push_back(2'b11);
    check("s3_fill_full", 32'(fill_level), 32'd4);
    check("s3_ovf_pre",   32'(overflow),   32'd0);
    send_pixel(2'b01);
    check("s3_fill_after", 32'(fill_level), 32'd4);
    check("s3_ovf",        32'(overflow),   32'd1);
    drain("s3");
    check("s3_ovf_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("s3_ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop.
    send_pixel(2'b11); exp_q.push_back(2'b11);
    send_pixel(2'b10); exp_q.push_back(2'b10);
    send_pixel(2'b01); exp_q.push_back(2'b01);
    send_pixel(2'b00); exp_q.push_back(2'b00);
    send_bit(1'b0);
    check("s4_head", 32'(pixel_data), 32'(exp_q.pop_front()));
    pixel_ready = 1'b1;
    send_bit(1'b1);
    pixel_ready = 1'b0;
    exp_q.push_back(2'b01);
    check("s4_fill", 32'(fill_level), 32'd4);
    check("s4_ovf",  32'(overflow),   32'd0);
    drain("s4");

    // Flush drops the buffered pixel and the stale partial bit.
    send_pixel(2'b01);
    send_bit(1'b1);
    flush     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    tick();
    flush     = 1'b0;
    bit_valid = 1'b0;
    check("s5_fill_flush", 32'(fill_level), 32'd0);
    send_bit(1'b1);
    check("s5_fill_half", 32'(fill_level), 32'd0);
    send_bit(1'b1);
    exp_q.push_back(2'b11);
    drain("s5");

    // Asynchronous reset mid-cycle with 3 entries and one partial bit.
    send_pixel(2'b01);
    send_pixel(2'b10);
    send_pixel(2'b11);
    send_bit(1'b1);
    check("s6_fill_pre", 32'(fill_level), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("s6_valid_rst", 32'(pixel_valid), 32'd0);
    check("s6_fill_rst",  32'(fill_level),  32'd0);
    check("s6_data_rst",  32'(pixel_data),  32'd0);
    tick();
    reset = 1'b1;
    send_bit(1'b1);
    check("s6_fill_half", 32'(fill_level), 32'd0);
    send_bit(1'b0);
    exp_q.push_back(2'b10);
    check("s6_fill_one", 32'(fill_level), 32'd1);
    drain("s6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter PIXEL_BITS, default 2: bits per packed pixel; legal range 1..8.
REQ-002 Parameter FIFO_DEPTH, default 4: pixel entries buffered; power of two, minimum 2.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port bit_valid  input  1  strobe meaning bit_in carries one result bit from the core array (its valid_bit).
REQ-006 Port bit_in  input  1  serial result bit (the core array's output_bit).
REQ-007 Port flush  input  1  synchronous clear of the partial pixel and the FIFO.
REQ-008 Port clear_overflow  input  1  synchronous clear of the sticky overflow flag.
REQ-009 Port pixel_data  output  PIXEL_BITS  head-of-FIFO pixel.
REQ-010 Port pixel_valid  output  1  FIFO not empty.
REQ-011 Port pixel_ready  input  1  downstream VGA stage accepts pixel_data this cycle.
REQ-012 Port fill_level  output  clog2(FIFO_DEPTH)+1  number of FIFO entries occupied.
REQ-013 Port overflow  output  1  sticky flag: a completed pixel was dropped.

Function
REQ-014 Shifter: on each cycle with bit_valid=1, bit_in is shifted into the partial-pixel register MSB-first (first bit received becomes pixel MSB), and bit_cnt increments.
REQ-015 Pixel completion: the bit_valid cycle with bit_cnt = PIXEL_BITS-1 forms the full pixel {partial, bit_in}, requests a FIFO push in that same cycle, and resets bit_cnt to 0; latency from the last bit to pixel_valid is 1 cycle when the FIFO is empty.
REQ-016 Cycles with bit_valid=0 leave the shifter and bit_cnt unchanged; bit_in is ignored.
REQ-017 Pop: a FIFO entry is removed on a cycle where pixel_valid=1 and pixel_ready=1; pixel_ready while empty has no effect.
REQ-018 pixel_data is valid only while pixel_valid=1 and stays stable until popped.
REQ-019 Push while not full: entry written, fill_level increments (unless a pop occurs in the same cycle, in which case fill_level is unchanged).
REQ-020 Push while full with simultaneous pop: push accepted, fill_level stays FIFO_DEPTH, overflow not set.
REQ-021 Push while full without pop: pixel is discarded, FIFO unchanged, overflow set to 1 on the next edge.
REQ-022 The overflow flag remains set until clear_overflow or reset; if clear_overflow and a new overflow occur in the same cycle, overflow stays 1.
REQ-023 Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
REQ-024 flush=1: on the next edge bit_cnt=0, partial=0, and the FIFO is empty; any bit_valid, push, or pop in the same cycle is ignored; overflow is unaffected.
REQ-025 The block has no combinational path from bit_valid or bit_in to any output; pixel_valid and fill_level are derived from registered state only.

Reset
REQ-026 While reset=0: bit_cnt=0, partial=0, FIFO pointers=0, fill_level=0, pixel_valid=0, overflow=0, and pixel_data=0.
REQ-027 Reset asserted during an operation aborts any partial pixel and empties the FIFO immediately, without waiting for clk.
REQ-028 Deassertion of reset takes effect at the first rising edge of clk after release; bits presented before that edge are not captured.

Structure
REQ-029 PIXEL_BITS default, FIFO_DEPTH default, and the derived pointer and level widths are defined in the shared GPU constants include, alongside the core-array parameters.
REQ-030 The FIFO is implemented as a sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full, level; same clk and reset), instantiated once; the shifter and overflow logic live in pixel_packer.

Verification
REQ-031 Scenario: PIXEL_BITS=2, pixel_ready=1, with bits 1,0 then 1,1 on consecutive bit_valid cycles -> pixel_data=2'b10 then 2'b11, each with pixel_valid high for one cycle, starting 1 cycle after the second bit.
REQ-032 Scenario: bit_valid pulses separated by idle cycles (bit 0, 3 idle cycles, bit 1) -> one pixel 2'b01; idle cycles do not disturb bit_cnt.
REQ-033 Scenario: pixel_ready=0 and 5 pixels pushed with FIFO_DEPTH=4 -> fill_level=4, overflow=1, and draining yields the first 4 pixels in order; clear_overflow then returns overflow to 0.
REQ-034 Scenario: FIFO full, with a push and a pop in the same cycle -> fill_level stays 4, overflow stays 0, and the new pixel appears last on drain.
REQ-035 Scenario: one bit received, then flush, then bits 1,1 -> only pixel 2'b11 is emitted and the stale bit is lost.
REQ-036 Scenario: reset asserted asynchronously mid-cycle while the FIFO holds 3 entries and 1 partial bit is pending -> pixel_valid=0 and fill_level=0 immediately; after release, the first two bits form a fresh pixel.
